// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter: port 0 MEMORY, port 1 FETCH, with an outstanding-request cap.
// Define ARB_ROUND_ROBIN_EN for round-robin ties in IDLE; otherwise port 0 wins ties.
module wb_arbiter #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_wb_cyc_i,
    input  logic        m0_wb_stb_i,
    input  logic        m0_wb_we_i,
    input  logic [15:0] m0_wb_addr_i,
    input  logic [15:0] m0_wb_data_i,
    output logic        m0_wb_stall_o,
    output logic        m0_wb_ack_o,
    output logic [15:0] m0_wb_data_o,

    input  logic        m1_wb_cyc_i,
    input  logic        m1_wb_stb_i,
    input  logic        m1_wb_we_i,
    input  logic [15:0] m1_wb_addr_i,
    input  logic [15:0] m1_wb_data_i,
    output logic        m1_wb_stall_o,
    output logic        m1_wb_ack_o,
    output logic [15:0] m1_wb_data_o,

    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [15:0] wb_addr_o,
    output logic [15:0] wb_data_o,
    input  logic        wb_stall_i,
    input  logic        wb_ack_i,
    input  logic [15:0] wb_data_i
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT0,
        GRANT1
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

    state_t     state, state_d;
    logic       last_grant, last_grant_d;
    logic [3:0] outst, outst_d;
    logic       cap_stall;
    logic       accept;
    logic       dec;
    logic       tie_m1;

`ifdef ARB_ROUND_ROBIN_EN
    assign tie_m1 = ~last_grant;
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign tie_m1 = 1'b0;
`endif

    always_comb begin
        state_d      = state;
        last_grant_d = last_grant;
        unique case (state)
            IDLE: begin
                if (m0_wb_cyc_i && m1_wb_cyc_i)
                    state_d = tie_m1 ? GRANT1 : GRANT0;
                else if (m0_wb_cyc_i)
                    state_d = GRANT0;
                else if (m1_wb_cyc_i)
                    state_d = GRANT1;
            end
            GRANT0: begin
                if (!m0_wb_cyc_i)
                    state_d = m1_wb_cyc_i ? GRANT1 : IDLE;
            end
            GRANT1: begin
                if (!m1_wb_cyc_i)
                    state_d = m0_wb_cyc_i ? GRANT0 : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == GRANT0)
            last_grant_d = 1'b0;
        else if (state_d == GRANT1)
            last_grant_d = 1'b1;
    end

    // An ack in the same cycle frees a slot, so it lifts the cap immediately.
    assign cap_stall = (outst == MAX_CNT) & ~wb_ack_i;

    always_comb begin
        wb_cyc_o      = 1'b0;
        wb_stb_o      = 1'b0;
        wb_we_o       = 1'b0;
        wb_addr_o     = '0;
        wb_data_o     = '0;
        m0_wb_stall_o = 1'b1;
        m0_wb_ack_o   = 1'b0;
        m1_wb_stall_o = 1'b1;
        m1_wb_ack_o   = 1'b0;
        unique case (state)
            GRANT0: begin
                wb_cyc_o      = m0_wb_cyc_i;
                wb_stb_o      = m0_wb_stb_i & ~cap_stall;
                wb_we_o       = m0_wb_we_i;
                wb_addr_o     = m0_wb_addr_i;
                wb_data_o     = m0_wb_data_i;
                m0_wb_stall_o = wb_stall_i | cap_stall;
                m0_wb_ack_o   = wb_ack_i & m0_wb_cyc_i;
            end
            GRANT1: begin
                wb_cyc_o      = m1_wb_cyc_i;
                wb_stb_o      = m1_wb_stb_i & ~cap_stall;
                wb_we_o       = m1_wb_we_i;
                wb_addr_o     = m1_wb_addr_i;
                wb_data_o     = m1_wb_data_i;
                m1_wb_stall_o = wb_stall_i | cap_stall;
                m1_wb_ack_o   = wb_ack_i & m1_wb_cyc_i;
            end
            default: ;
        endcase
    end

    assign m0_wb_data_o = wb_data_i;
    assign m1_wb_data_o = wb_data_i;

    assign accept = wb_stb_o & ~wb_stall_i;
    assign dec    = wb_ack_i & (outst != 4'd0);

    // Dropping cyc ends the transaction, so stale acks are never counted.
    always_comb begin
        outst_d = outst;
        if (!wb_cyc_o)
            outst_d = 4'd0;
        else if (accept && !dec && outst != 4'hF)
            outst_d = outst + 4'd1;
        else if (dec && !accept)
            outst_d = outst - 4'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            outst      <= 4'd0;
        end else begin
            state      <= state_d;
            last_grant <= last_grant_d;
            outst      <= outst_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed plus randomized bench for wb_arbiter.
// Every cycle is compared against a rule-level ownership/credit model.
module tb_wb_arbiter;

    localparam int MAX = 3;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        c [2];
    logic        s [2];
    logic        w [2];
    logic [15:0] a [2];
    logic [15:0] d [2];
    logic        stall_i = 1'b0;
    logic        ack_i = 1'b0;
    logic [15:0] rdata = '0;

    logic        m0_stall, m0_ack, m1_stall, m1_ack;
    logic [15:0] m0_rd, m1_rd;
    logic        cyc_o, stb_o, we_o;
    logic [15:0] addr_o, data_o;

    wb_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_wb_cyc_i(c[0]), .m0_wb_stb_i(s[0]), .m0_wb_we_i(w[0]),
        .m0_wb_addr_i(a[0]), .m0_wb_data_i(d[0]),
        .m0_wb_stall_o(m0_stall), .m0_wb_ack_o(m0_ack), .m0_wb_data_o(m0_rd),
        .m1_wb_cyc_i(c[1]), .m1_wb_stb_i(s[1]), .m1_wb_we_i(w[1]),
        .m1_wb_addr_i(a[1]), .m1_wb_data_i(d[1]),
        .m1_wb_stall_o(m1_stall), .m1_wb_ack_o(m1_ack), .m1_wb_data_o(m1_rd),
        .wb_cyc_o(cyc_o), .wb_stb_o(stb_o), .wb_we_o(we_o),
        .wb_addr_o(addr_o), .wb_data_o(data_o),
        .wb_stall_i(stall_i), .wb_ack_i(ack_i), .wb_data_i(rdata)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: who owns the bus (-1 none), who was last granted, accepted-unacked count.
    int owner = -1;
    int last = 1;
    int pend = 0;
    logic e_cyc, e_stb;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output with the model, mid-cycle.
    task automatic settle();
        logic cap;
        logic [15:0] e_addr, e_data;
        logic e_we;
        @(negedge clk);
        cap    = (owner >= 0) && (pend == MAX) && !ack_i;
        e_cyc  = (owner >= 0) ? c[owner] : 1'b0;
        e_stb  = (owner >= 0) ? (s[owner] && !cap) : 1'b0;
        e_we   = (owner >= 0) ? w[owner] : 1'b0;
        e_addr = (owner >= 0) ? a[owner] : 16'h0;
        e_data = (owner >= 0) ? d[owner] : 16'h0;
        chk1("cyc_o", cyc_o, e_cyc);
        chk1("stb_o", stb_o, e_stb);
        chk1("we_o", we_o, e_we);
        chk16("addr_o", addr_o, e_addr);
        chk16("data_o", data_o, e_data);
        chk1("m0_stall", m0_stall, (owner == 0) ? (stall_i || cap) : 1'b1);
        chk1("m1_stall", m1_stall, (owner == 1) ? (stall_i || cap) : 1'b1);
        chk1("m0_ack", m0_ack, (owner == 0) ? (ack_i && c[0]) : 1'b0);
        chk1("m1_ack", m1_ack, (owner == 1) ? (ack_i && c[1]) : 1'b0);
        chk16("m0_rdata", m0_rd, rdata);
        chk16("m1_rdata", m1_rd, rdata);
        chk16("outst", {12'h0, dut.outst}, 16'(pend));
    endtask

    // Clock edge: advance the model with the inputs held during this cycle.
    task automatic adv();
        bit acc, dc;
        int nxt;
        @(posedge clk);
        if (rst) begin
            owner = -1;
            last  = 1;
            pend  = 0;
        end else begin
            acc = e_stb && !stall_i;
            dc  = ack_i && (pend > 0);
            if (!e_cyc)
                pend = 0;
            else if (acc && !dc)
                pend++;
            else if (dc && !acc)
                pend--;
            nxt = owner;
            if (owner < 0) begin
                if (c[0] && c[1])
                    nxt = (RR && last == 0) ? 1 : 0;
                else if (c[0])
                    nxt = 0;
                else if (c[1])
                    nxt = 1;
            end else if (!c[owner]) begin
                nxt = c[1 - owner] ? 1 - owner : -1;
            end
            if (nxt >= 0)
                last = nxt;
            owner = nxt;
        end
        #1;
    endtask

    task automatic step();
        settle();
        adv();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            c[k] = 0; s[k] = 0; w[k] = 0; a[k] = '0; d[k] = '0;
        end
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        settle();
        chk1("rst_m0_stall", m0_stall, 1'b1);
        chk1("rst_m1_stall", m1_stall, 1'b1);
        chk1("rst_cyc", cyc_o, 1'b0);
        chk16("rst_addr", addr_o, 16'h0);
        adv();

        c[1] = 1; s[1] = 1; a[1] = 16'h0010;
        settle();
        chk1("arb_wait_stall", m1_stall, 1'b1);
        chk1("arb_wait_cyc", cyc_o, 1'b0);
        adv();
        settle();
        chk1("arb_grant_cyc", cyc_o, 1'b1);
        chk16("arb_grant_addr", addr_o, 16'h0010);
        adv();
        s[1] = 0; ack_i = 1; rdata = 16'hBEEF;
        settle();
        chk1("ack_m1", m1_ack, 1'b1);
        chk16("ack_m1_data", m1_rd, 16'hBEEF);
        chk1("ack_m0_quiet", m0_ack, 1'b0);
        adv();
        ack_i = 0; c[1] = 0;
        step();

        c[0] = 1; c[1] = 1;
        step();
        settle();
        chk1("tie1_m0_stall", m0_stall, 1'b0);
        chk1("tie1_m1_stall", m1_stall, 1'b1);
        adv();
        c[0] = 0; c[1] = 0;
        step();
        c[0] = 1; c[1] = 1;
        step();
        settle();
        chk1("tie2_m0_stall", m0_stall, RR);
        chk1("tie2_m1_stall", m1_stall, !RR);
        adv();
        c[0] = 0; c[1] = 0;
        step();

        c[1] = 1; a[1] = 16'h0100;
        step();
        c[0] = 1; s[0] = 1; a[0] = 16'h2000;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk1("hold_m0_stall", m0_stall, 1'b1);
            chk16("hold_addr", addr_o, 16'h0100);
            adv();
        end
        c[1] = 0;
        settle();
        chk1("gap_cyc", cyc_o, 1'b0);
        chk1("gap_m0_stall", m0_stall, 1'b1);
        adv();
        settle();
        chk1("hand_cyc", cyc_o, 1'b1);
        chk16("hand_addr", addr_o, 16'h2000);
        adv();

        step();
        step();
        settle();
        chk1("cap_stall", m0_stall, 1'b1);
        chk1("cap_stb", stb_o, 1'b0);
        adv();
        ack_i = 1;
        settle();
        chk1("cap_ack_stall", m0_stall, 1'b0);
        chk1("cap_ack_stb", stb_o, 1'b1);
        adv();
        ack_i = 0;
        settle();
        chk1("cap_again", m0_stall, 1'b1);
        chk16("cap_full", {12'h0, dut.outst}, 16'd3);
        adv();

        rst = 1;
        step();
        rst = 0;
        settle();
        chk1("mrst_cyc", cyc_o, 1'b0);
        chk1("mrst_m0_stall", m0_stall, 1'b1);
        chk1("mrst_m1_stall", m1_stall, 1'b1);
        chk16("mrst_outst", {12'h0, dut.outst}, 16'd0);
        adv();
        c[0] = 0; s[0] = 0;
        step();

        c[1] = 1; s[1] = 1;
        step();
        step();
        s[1] = 0;
        settle();
        chk16("abort_outst1", {12'h0, dut.outst}, 16'd1);
        adv();
        c[1] = 0;
        step();
        ack_i = 1;
        settle();
        chk1("abort_m0_ack", m0_ack, 1'b0);
        chk1("abort_m1_ack", m1_ack, 1'b0);
        adv();
        ack_i = 0;
        settle();
        chk16("abort_outst0", {12'h0, dut.outst}, 16'd0);
        adv();

        for (int n = 0; n < 600; n++) begin
            bit cyc_now;
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(5) == 0)
                    c[k] = ~c[k];
                s[k] = 1'($urandom_range(1));
                w[k] = 1'($urandom_range(1));
                a[k] = 16'($urandom);
                d[k] = 16'($urandom);
            end
            cyc_now = (owner >= 0) && c[owner];
            stall_i = ($urandom_range(3) == 0);
            ack_i   = ($urandom_range(2) == 0) && (pend > 0 || !cyc_now);
            rdata   = 16'($urandom);
            rst     = ($urandom_range(79) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
